// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: mining-loop sequencer between the nonce
// incrementer and a SHA-256d core; tracks hits, wrap and stalls.
module nonce_search_ctrl #(
  parameter int NONCE_W  = 32,
  parameter int DIGEST_W = 256,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [NONCE_W-1:0]  nonce,
  output logic                update,
  output logic                hash_start,
  output logic [NONCE_W-1:0]  hash_nonce,
  input  logic                hash_done,
  input  logic [DIGEST_W-1:0] hash_digest,
  input  logic [DIGEST_W-1:0] target,
  output logic                busy,
  output logic                found,
  output logic [NONCE_W-1:0]  golden_nonce,
  output logic                exhausted,
  output logic                timeout_err,
  output logic [31:0]         hash_count
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WMAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMPARE,
    ADVANCE,
    FOUND,
    EXHAUSTED,
    ERROR
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [NONCE_W-1:0]  nonce_q;
  logic [DIGEST_W-1:0] digest_q;
  logic [CW-1:0]       wait_cnt;
  logic                hit;
  logic                last;
  logic                halt;

  assign hit  = digest_q <= target;
  assign last = &nonce_q;
  assign halt = stop && (state != IDLE);

  // ISSUE forwards the live nonce so it is valid with hash_start
  assign hash_nonce = (state == ISSUE) ? nonce : nonce_q;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next-state decode and handshake pulses
  always_comb begin
    state_n    = state;
    update     = 1'b0;
    hash_start = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) state_n = ISSUE;
      end
      ISSUE: begin
        busy       = 1'b1;
        hash_start = 1'b1;
        state_n    = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (hash_done)            state_n = COMPARE;
        else if (wait_cnt == WMAX) state_n = ERROR;
      end
      COMPARE: begin
        busy = 1'b1;
        if (hit)       state_n = FOUND;
        else if (last) state_n = EXHAUSTED;
        else           state_n = ADVANCE;
      end
      ADVANCE: begin
        busy    = 1'b1;
        update  = 1'b1;
        state_n = ISSUE;
      end
      FOUND: begin
        if (start) state_n = ADVANCE;
      end
      EXHAUSTED, ERROR: begin
        if (start) state_n = ISSUE;
      end
      default: state_n = IDLE;
    endcase
    if (halt) state_n = IDLE;
  end

  // datapath, result counters and sticky status
  always_ff @(posedge clk) begin
    if (!reset) begin
      nonce_q      <= '0;
      digest_q     <= '0;
      wait_cnt     <= '0;
      hash_count   <= '0;
      golden_nonce <= '0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      found       <= state_n == FOUND;
      exhausted   <= state_n == EXHAUSTED;
      timeout_err <= state_n == ERROR;
      if (state == ISSUE) begin
        nonce_q  <= nonce;
        wait_cnt <= '0;
      end
      if (state == WAIT) begin
        if (hash_done) digest_q <= hash_digest;
        else           wait_cnt <= wait_cnt + CW'(1);
      end
      if (state == COMPARE && !halt) begin
        hash_count <= hash_count + 32'd1;
        if (hit) golden_nonce <= nonce_q;
      end
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb_nonce_search_ctrl: directed scenarios with a cycle-timed
// expectation model and a per-cycle compare of every output.
module tb_nonce_search_ctrl;

  localparam int NW  = 32;
  localparam int DW  = 256;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [NW-1:0] nonce;
  logic          update;
  logic          hash_start;
  logic [NW-1:0] hash_nonce;
  logic          hash_done = 1'b0;
  logic [DW-1:0] hash_digest = '0;
  logic [DW-1:0] target = '0;
  logic          busy;
  logic          found;
  logic [NW-1:0] golden_nonce;
  logic          exhausted;
  logic          timeout_err;
  logic [31:0]   hash_count;

  nonce_search_ctrl #(
    .NONCE_W (NW),
    .DIGEST_W(DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .nonce       (nonce),
    .update      (update),
    .hash_start  (hash_start),
    .hash_nonce  (hash_nonce),
    .hash_done   (hash_done),
    .hash_digest (hash_digest),
    .target      (target),
    .busy        (busy),
    .found       (found),
    .golden_nonce(golden_nonce),
    .exhausted   (exhausted),
    .timeout_err (timeout_err),
    .hash_count  (hash_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // nonce source: preloadable, advances on update
  logic          nonce_load = 1'b0;
  logic [NW-1:0] nonce_pre = '0;
  always @(posedge clk) begin
    if (nonce_load)  nonce <= nonce_pre;
    else if (update) nonce <= nonce + 1;
  end

  // hash core: answers each hash_start after hc_lat cycles
  logic          hc_on = 1'b1;
  int            hc_lat = 2;
  int            hc_cnt = 0;
  logic [NW-1:0] hc_nonce = '0;
  logic          hit_en = 1'b0;
  logic [NW-1:0] hit_nonce = '0;
  logic [DW-1:0] hit_dig = '0;
  logic [DW-1:0] miss_dig = '0;
  logic          hs_flag = 1'b0;
  logic [NW-1:0] hs_nonce_l = '0;

  always @(posedge clk) begin
    #1;
    hash_done = 1'b0;
    if (hs_flag && hc_on) begin
      hc_cnt   = hc_lat;
      hc_nonce = hs_nonce_l;
    end
    if (hc_cnt > 0) begin
      hc_cnt--;
      if (hc_cnt == 0) begin
        hash_done   = 1'b1;
        hash_digest = (hit_en && hc_nonce == hit_nonce) ? hit_dig : miss_dig;
      end
    end
  end

  // expectation model: times are sample indices (one per negedge)
  int            sn = 0;
  int            hs_at = -1;
  int            upd_at = -1;
  int            res_at = -1;
  int            live_at = 0;
  int            upd_cnt = 0;
  bit            live = 1'b0;
  bit            idle_m = 1'b1;
  bit            armed = 1'b0;
  bit            e_found = 1'b0;
  bit            e_exh = 1'b0;
  bit            e_tmo = 1'b0;
  bit            e_busy = 1'b0;
  logic [NW-1:0] e_golden = '0;
  logic [31:0]   e_count = '0;
  logic [NW-1:0] iss_nonce = '0;
  logic [DW-1:0] res_dig = '0;

  // compare every cycle, then advance the model by one cycle
  always @(negedge clk) begin
    sn++;
    hs_flag    = hash_start;
    hs_nonce_l = hash_nonce;
    if (update) upd_cnt++;
    if (sn == hs_at) iss_nonce = nonce;
    if (armed) begin
      chk("upd_and_hs", 64'(update & hash_start), 64'(0));
      chk("hash_start", 64'(hash_start), 64'(sn == hs_at));
      chk("update", 64'(update), 64'(sn == upd_at));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("found", 64'(found), 64'(e_found));
      chk("exhausted", 64'(exhausted), 64'(e_exh));
      chk("timeout_err", 64'(timeout_err), 64'(e_tmo));
      chk("hash_count", 64'(hash_count), 64'(e_count));
      chk("golden_nonce", 64'(golden_nonce), 64'(e_golden));
      if (sn == hs_at || live)
        chk("hash_nonce", 64'(hash_nonce), 64'(iss_nonce));
    end
    if (!reset) begin
      armed = 1'b1; idle_m = 1'b1; live = 1'b0;
      hs_at = -1; upd_at = -1; res_at = -1;
      e_found = 1'b0; e_exh = 1'b0; e_tmo = 1'b0;
      e_golden = '0; e_count = '0;
    end else if (stop) begin
      if (!idle_m) begin
        idle_m = 1'b1; live = 1'b0;
        hs_at = -1; upd_at = -1; res_at = -1;
        e_found = 1'b0; e_exh = 1'b0; e_tmo = 1'b0;
      end
    end else begin
      if (start) begin
        if (idle_m) begin
          idle_m = 1'b0;
          hs_at  = sn + 1;
        end else if (e_found) begin
          e_found = 1'b0;
          upd_at  = sn + 1;
        end else if (e_exh || e_tmo) begin
          e_exh = 1'b0;
          e_tmo = 1'b0;
          hs_at = sn + 1;
        end
      end
      if (live) begin
        if (hash_done) begin
          res_at  = sn + 2;
          res_dig = hash_digest;
          live    = 1'b0;
        end else if (sn - live_at == TMO) begin
          e_tmo = 1'b1;
          live  = 1'b0;
        end
      end
      if (sn == hs_at) begin
        live    = 1'b1;
        live_at = sn;
      end
      if (sn == upd_at) hs_at = sn + 1;
      if (res_at == sn + 1) begin
        e_count = e_count + 1;
        if (res_dig <= target) begin
          e_found  = 1'b1;
          e_golden = iss_nonce;
        end else if (&iss_nonce) begin
          e_exh = 1'b1;
        end else begin
          upd_at = sn + 1;
        end
      end
    end
    e_busy = !idle_m && !(e_found || e_exh || e_tmo);
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic preload(input logic [NW-1:0] v);
    @(posedge clk); #1 nonce_load = 1'b1; nonce_pre = v;
    @(posedge clk); #1 nonce_load = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p);
    @(posedge clk); #1 start = s; stop = p;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, 64'(busy), 64'(0));
  endtask

  task automatic wait_hs(input string name, input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (hash_start) break;
    end
    chk(name, 64'(hash_start), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  int u0;
  int k;

  initial begin
    do_reset();
    settle();
    chk("rst_count", 64'(hash_count), 64'(0));
    chk("rst_golden", 64'(golden_nonce), 64'(0));
    chk("rst_hash_nonce", 64'(hash_nonce), 64'(0));
    chk("rst_found", 64'(found), 64'(0));

    // 1: everything hits on the first digest
    preload(32'h1234);
    target = '1; hit_en = 1'b0; miss_dig = 256'hABC; hc_lat = 2;
    u0 = upd_cnt;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("t1_hs_latency", 64'(hash_start), 64'(1));
    wait_idle("t1_idle", 50);
    settle();
    chk("t1_found", 64'(found), 64'(1));
    chk("t1_golden", 64'(golden_nonce), 64'h1234);
    chk("t1_count", 64'(hash_count), 64'(1));
    chk("t1_updates", 64'(upd_cnt - u0), 64'(0));

    // 2: hit at nonce 4, then resume to a hit at 6
    do_reset();
    preload(32'd0);
    target = '0; hit_en = 1'b1; hit_nonce = 32'd4;
    hit_dig = '0; miss_dig = 256'd1;
    u0 = upd_cnt;
    pulse(1'b1, 1'b0);
    wait_idle("t2_idle", 200);
    settle();
    chk("t2_updates", 64'(upd_cnt - u0), 64'(4));
    chk("t2_golden", 64'(golden_nonce), 64'(4));
    chk("t2_count", 64'(hash_count), 64'(5));
    hit_nonce = 32'd6;
    pulse(1'b1, 1'b0);
    wait_idle("t2r_idle", 200);
    settle();
    chk("t2r_golden", 64'(golden_nonce), 64'(6));
    chk("t2r_count", 64'(hash_count), 64'(7));
    chk("t2r_updates", 64'(upd_cnt - u0), 64'(6));

    // 3: nonce space runs out at all-ones
    do_reset();
    preload(32'hFFFF_FFFE);
    target = '0; hit_en = 1'b0; miss_dig = 256'd1;
    u0 = upd_cnt;
    pulse(1'b1, 1'b0);
    wait_idle("t3_idle", 100);
    settle();
    chk("t3_exhausted", 64'(exhausted), 64'(1));
    chk("t3_count", 64'(hash_count), 64'(2));
    chk("t3_updates", 64'(upd_cnt - u0), 64'(1));
    repeat (5) @(posedge clk);
    chk("t3_no_more_upd", 64'(upd_cnt - u0), 64'(1));
    pulse(1'b1, 1'b0);
    wait_idle("t3r_idle", 100);
    settle();
    chk("t3r_exhausted", 64'(exhausted), 64'(1));
    chk("t3r_count", 64'(hash_count), 64'(3));

    // 4: hash core never answers
    do_reset();
    preload(32'd77);
    hc_on = 1'b0;
    pulse(1'b1, 1'b0);
    wait_hs("t4_hs", 10);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (timeout_err) break;
    end
    chk("t4_edges_to_timeout", 64'(k - 1), 64'(16));
    chk("t4_busy", 64'(busy), 64'(0));
    hc_on = 1'b1; target = '1;
    pulse(1'b1, 1'b0);
    wait_idle("t4r_idle", 50);
    settle();
    chk("t4r_golden", 64'(golden_nonce), 64'(77));
    chk("t4r_timeout", 64'(timeout_err), 64'(0));

    // 5: stop during WAIT, late result must be dropped
    do_reset();
    preload(32'd10);
    target = '0; hit_en = 1'b1; hit_nonce = 32'd11;
    hit_dig = '0; miss_dig = 256'd1; hc_lat = 3;
    u0 = upd_cnt;
    pulse(1'b1, 1'b0);
    wait_idle("t5_idle", 100);
    settle();
    chk("t5_golden", 64'(golden_nonce), 64'(11));
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    wait_hs("t5_hs", 10);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    repeat (8) @(posedge clk);
    chk("t5_count", 64'(hash_count), 64'(2));
    chk("t5_updates", 64'(upd_cnt - u0), 64'(1));
    chk("t5_found", 64'(found), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));

    // 6: reset mid-WAIT with start and stop together
    do_reset();
    preload(32'd20);
    target = '1; hc_lat = 8;
    pulse(1'b1, 1'b0);
    wait_hs("t6_hs", 10);
    @(posedge clk); #1 reset = 1'b0; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 reset = 1'b1; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_hash_nonce", 64'(hash_nonce), 64'(0));
    chk("t6_count", 64'(hash_count), 64'(0));
    pulse(1'b1, 1'b1);
    repeat (12) @(posedge clk);
    chk("t6_idle", 64'(busy), 64'(0));
    chk("t6_found", 64'(found), 64'(0));

    // 7: digest equal to target is a hit, one above is not
    do_reset();
    preload(32'd0);
    target = 256'd100; hit_en = 1'b1; hit_nonce = 32'd2;
    hit_dig = 256'd100; miss_dig = 256'd101; hc_lat = 1;
    u0 = upd_cnt;
    pulse(1'b1, 1'b0);
    wait_idle("t7_idle", 100);
    settle();
    chk("t7_golden", 64'(golden_nonce), 64'(2));
    chk("t7_count", 64'(hash_count), 64'(3));
    chk("t7_updates", 64'(upd_cnt - u0), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
